// File: rtl/branch_update_queue.sv
// branch_update_queue: in-order queue of predicted branches feeding predictor updates.
// Optional stats counters (UpdateCount/MispredictCount) under BRANCH_UPDATE_STATS_EN.
module branch_update_queue #(
    parameter int DEPTH = 8,
    parameter int PC_W  = 32,
    parameter int CNT_W = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             EnqValid,
    input  logic [PC_W-1:0]  EnqPC,
    input  logic             EnqPredTaken,
    output logic             EnqReady,
    input  logic             ResValid,
    input  logic             ResTaken,
    output logic             ResReady,
    input  logic             Flush,
    output logic             isBranch,
    output logic             isTaken,
    output logic [PC_W-1:0]  InstrPC,
    output logic             Mispredict,
    output logic [PC_W-1:0]  MispredictPC,
    output logic [CNT_W-1:0] Count
`ifdef BRANCH_UPDATE_STATS_EN
    ,
    output logic [31:0]      UpdateCount,
    output logic [31:0]      MispredictCount
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] L_FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_GAP
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [PC_W-1:0]  r_pc [DEPTH];
    logic [DEPTH-1:0] r_pred;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_enq;
    logic             w_res;
    logic             w_miss;
    logic [PC_W-1:0]  w_head_pc;
    logic             w_head_pred;
    logic             r_is_taken;
    logic             r_mispredict;
    logic [PC_W-1:0]  r_instr_pc;
    logic [PC_W-1:0]  r_mis_pc;

    assign EnqReady    = (r_count != L_FULL);
    assign ResReady    = (r_count != '0) && (r_state == S_IDLE);
    assign w_enq       = EnqValid && EnqReady && !Flush;
    assign w_res       = ResValid && ResReady;
    assign w_head_pc   = r_pc[r_rd_ptr];
    assign w_head_pred = r_pred[r_rd_ptr];
    assign w_miss      = (ResTaken != w_head_pred);

    assign Count        = r_count;
    assign InstrPC      = r_instr_pc;
    assign isTaken      = r_is_taken;
    assign Mispredict   = r_mispredict;
    assign MispredictPC = r_mis_pc;

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge CLK) begin
        if (w_enq) begin
            r_pc[r_wr_ptr]   <= EnqPC;
            r_pred[r_wr_ptr] <= EnqPredTaken;
        end
    end

    // Pointers and occupancy; flush empties the queue after any same-cycle pop.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (Flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_res) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_enq && !w_res) r_count <= r_count + CNT_W'(1);
            else if (!w_enq && w_res) r_count <= r_count - CNT_W'(1);
        end
    end

    // Update operands captured at resolve; mispredict is a single-cycle pulse.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_instr_pc   <= '0;
            r_is_taken   <= 1'b0;
            r_mispredict <= 1'b0;
            r_mis_pc     <= '0;
        end else if (w_res) begin
            r_instr_pc   <= w_head_pc;
            r_is_taken   <= ResTaken;
            r_mispredict <= w_miss;
            if (w_miss) r_mis_pc <= w_head_pc;
        end else begin
            r_mispredict <= 1'b0;
        end
    end

    // Sequencer state register.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Sequencer next state: setup, strobe, gap, then idle.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_res) w_next = S_SETUP;
            S_SETUP: w_next = S_PULSE;
            S_PULSE: w_next = S_GAP;
            S_GAP:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Sequencer output: strobe high only in PULSE.
    always_comb begin
        isBranch = 1'b0;
        if (r_state == S_PULSE) isBranch = 1'b1;
    end

`ifdef BRANCH_UPDATE_STATS_EN
    logic [31:0] r_upd_cnt;
    logic [31:0] r_mis_cnt;

    assign UpdateCount     = r_upd_cnt;
    assign MispredictCount = r_mis_cnt;

    // Saturating update/mispredict counters, cleared by reset only.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_upd_cnt <= '0;
            r_mis_cnt <= '0;
        end else begin
            if (r_state == S_SETUP && r_upd_cnt != '1)
                r_upd_cnt <= r_upd_cnt + 32'd1;
            if (w_res && w_miss && r_mis_cnt != '1)
                r_mis_cnt <= r_mis_cnt + 32'd1;
        end
    end
`endif

endmodule
